// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone classic arbiter:
// state encoding, master indices, grant codes and the tie-break rule.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // A lone requester wins; on a tie the master that was not granted last wins.
    function automatic arb_state_e arbitrate(input logic req0, input logic req1, input logic last);
        arb_state_e winner;
        winner = IDLE;
        if (req0 && req1) begin
            winner = (last == M1) ? OWN_M0 : OWN_M1;
        end else if (req0) begin
            winner = OWN_M0;
        end else if (req1) begin
            winner = OWN_M1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and pulses fire for one cycle
// when the count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run,
    input  logic clear,
    output logic fire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        fire    = 1'b0;
        if ((TIMEOUT_CYCLES == 0) || clear) begin
            count_d = '0;
        end else if (run) begin
            if (count_q == LIMIT) begin
                fire    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (M0 fetch, M1 load/store), one-slave Wishbone classic arbiter with
// round-robin tie-break, grant held for the whole bus cycle, and a hang watchdog.
module wb_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_addr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,

    output logic [1:0]        grant_o
);

    import wb_arb_pkg::*;

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       own_m0, own_m1;
    logic       rearbitrate;
    logic       wd_run, wd_clear, wd_fire;

    assign own_m0 = (state_q == OWN_M0);
    assign own_m1 = (state_q == OWN_M1);

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_dat_o  = '0;
        if (own_m0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_cyc_i & m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
        end else if (own_m1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_cyc_i & m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
        end
    end

    // The bus is up for grabs when idle or when the owner has dropped CYC;
    // handing over in that same edge avoids a dead cycle between owners.
    assign rearbitrate = !s_cyc_o;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (rearbitrate) begin
            state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_q);
            if (state_d == OWN_M0) begin
                last_d = M0;
            end else if (state_d == OWN_M1) begin
                last_d = M1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // A dropped strobe covers both an idle owner and a release or abort.
    assign wd_run   = s_stb_o;
    assign wd_clear = !s_stb_o || s_ack_i || s_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run    (wd_run),
        .clear  (wd_clear),
        .fire   (wd_fire)
    );

    assign m0_ack_o = own_m0 & s_ack_i & ~s_err_i;
    assign m1_ack_o = own_m1 & s_ack_i & ~s_err_i;
    assign m0_err_o = own_m0 & (s_err_i | wd_fire);
    assign m1_err_o = own_m1 & (s_err_i | wd_fire);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = own_m1 ? GRANT_M1 : (own_m0 ? GRANT_M0 : GRANT_NONE);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios followed by random
// traffic, all compared against an owner/last/stall-count reference model.
module tb_wb_bus_arbiter;

    localparam int TO = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [1:0]    grant_o;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(TO), .AW(AW), .DW(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: owner (-1 none), last granted master, consecutive stalled strobes.
    int owner_m = -1;
    int last_m  = 1;
    int stall_m = 0;
    bit e_stalled = 1'b0;
    bit e_fire    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner_m   = -1;
        last_m    = 1;
        stall_m   = 0;
        e_stalled = 1'b0;
        e_fire    = 1'b0;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = '0; m0_addr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = '0; m1_addr_i = '0; m1_dat_i = '0;
        s_ack_i  = 1'b0; s_err_i  = 1'b0;
    endtask

    // Check every output against the model at the falling edge.
    task automatic sample();
        logic [1:0]    g_e;
        logic          cyc_e, stb_e, we_e;
        logic [SW-1:0] sel_e;
        logic [AW-1:0] addr_e;
        logic [DW-1:0] wdat_e;
        @(negedge clk_i);
        g_e = 2'b00; cyc_e = 1'b0; stb_e = 1'b0; we_e = 1'b0; sel_e = '0; addr_e = '0; wdat_e = '0;
        if (owner_m == 0) begin
            g_e = 2'b01; cyc_e = m0_cyc_i; stb_e = m0_cyc_i && m0_stb_i; we_e = m0_we_i;
            sel_e = m0_sel_i; addr_e = m0_addr_i; wdat_e = m0_dat_i;
        end else if (owner_m == 1) begin
            g_e = 2'b10; cyc_e = m1_cyc_i; stb_e = m1_cyc_i && m1_stb_i; we_e = m1_we_i;
            sel_e = m1_sel_i; addr_e = m1_addr_i; wdat_e = m1_dat_i;
        end
        e_stalled = stb_e && !s_ack_i && !s_err_i;
        e_fire    = (TO > 0) && e_stalled && (stall_m == TO);
        chk("grant",  64'(grant_o),  64'(g_e));
        chk("s_cyc",  64'(s_cyc_o),  64'(cyc_e));
        chk("s_stb",  64'(s_stb_o),  64'(stb_e));
        chk("s_we",   64'(s_we_o),   64'(we_e));
        chk("s_sel",  64'(s_sel_o),  64'(sel_e));
        chk("s_addr", 64'(s_addr_o), 64'(addr_e));
        chk("s_dat",  64'(s_dat_o),  64'(wdat_e));
        chk("m0_ack", 64'(m0_ack_o), 64'(owner_m == 0 && s_ack_i && !s_err_i));
        chk("m1_ack", 64'(m1_ack_o), 64'(owner_m == 1 && s_ack_i && !s_err_i));
        chk("m0_err", 64'(m0_err_o), 64'(owner_m == 0 && (s_err_i || e_fire)));
        chk("m1_err", 64'(m1_err_o), 64'(owner_m == 1 && (s_err_i || e_fire)));
        chk("m0_dat", 64'(m0_dat_o), 64'(s_dat_i));
        chk("m1_dat", 64'(m1_dat_o), 64'(s_dat_i));
    endtask

    // Advance one rising edge and apply the arbitration rules to the model.
    task automatic tick();
        bit owner_cyc;
        @(posedge clk_i);
        stall_m = (e_stalled && !e_fire) ? stall_m + 1 : 0;
        owner_cyc = (owner_m == 0) ? m0_cyc_i : ((owner_m == 1) ? m1_cyc_i : 1'b0);
        if (!owner_cyc) begin
            if (m0_cyc_i && m1_cyc_i) owner_m = 1 - last_m;
            else if (m0_cyc_i)        owner_m = 0;
            else if (m1_cyc_i)        owner_m = 1;
            else                      owner_m = -1;
            if (owner_m >= 0) last_m = owner_m;
        end
        e_stalled = 1'b0;
        e_fire    = 1'b0;
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    initial begin
        bit c0, c1;
        idle_inputs();
        s_dat_i = 32'hA5A5_1234;

        // Outputs during reset
        #3;
        chk("rst_grant", 64'(grant_o), 64'(2'b00));
        chk("rst_s_cyc", 64'(s_cyc_o), 64'(1'b0));
        chk("rst_s_stb", 64'(s_stb_o), 64'(1'b0));
        chk("rst_m0_ack", 64'(m0_ack_o), 64'(1'b0));
        chk("rst_m0_dat", 64'(m0_dat_o), 64'(32'hA5A5_1234));
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        tick();

        // M0 read of 0x7FFFFFFC, slave ACKs on the third slave-side cycle
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_sel_i = 4'hF; m0_addr_i = 32'h7FFF_FFFC;
        step();
        sample();
        chk("rd_addr", 64'(s_addr_o), 64'(32'h7FFF_FFFC));
        chk("rd_noack", 64'(m0_ack_o), 64'(1'b0));
        tick();
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        sample();
        chk("rd_ack", 64'(m0_ack_o), 64'(1'b1));
        chk("rd_dat", 64'(m0_dat_o), 64'(32'hDEAD_BEEF));
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        sample();
        chk("rd_ack_once", 64'(m0_ack_o), 64'(1'b0));
        tick();

        // Asynchronous reset in the middle of an M0-owned cycle
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        step();
        #2;
        chk("pre_rst_grant", 64'(grant_o), 64'(2'b01));
        rst_ni = 1'b0;
        #1;
        chk("midrst_grant", 64'(grant_o), 64'(2'b00));
        chk("midrst_s_cyc", 64'(s_cyc_o), 64'(1'b0));
        chk("midrst_s_stb", 64'(s_stb_o), 64'(1'b0));
        model_reset();
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Simultaneous request after reset: M0 first, then handover to M1
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        s_ack_i = 1'b1;
        sample();
        chk("tie_first_m0", 64'(grant_o), 64'(2'b01));
        chk("tie_m1_noack", 64'(m1_ack_o), 64'(1'b0));
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        s_ack_i = 1'b1;
        sample();
        chk("handover_m1", 64'(grant_o), 64'(2'b10));
        chk("handover_m1_ack", 64'(m1_ack_o), 64'(1'b1));
        tick();
        idle_inputs();
        step();

        // Four back-to-back ties alternate M0, M1, M0, M1
        for (int i = 0; i < 4; i++) begin
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            step();
            s_ack_i = 1'b1;
            sample();
            chk("rr_grant", 64'(grant_o), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            chk("rr_nonowner_ack", 64'((i % 2 == 0) ? m1_ack_o : m0_ack_o), 64'(1'b0));
            tick();
            idle_inputs();
            step();
        end

        // Watchdog: slave never answers, ERR on the 5th strobe cycle only
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        for (int k = 1; k <= 7; k++) begin
            sample();
            chk("wd_err_pulse", 64'(m0_err_o), 64'(k == 5));
            tick();
        end
        idle_inputs();
        step();

        // ACK arriving in the would-be fire cycle wins over the watchdog
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            s_ack_i = (k == 5);
            sample();
            chk("wd_ack_wins_err", 64'(m1_err_o), 64'(1'b0));
            chk("wd_ack_wins_ack", 64'(m1_ack_o), 64'(k == 5));
            tick();
        end
        idle_inputs();
        step();

        // ACK and ERR together give ERR only
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        s_ack_i = 1'b1; s_err_i = 1'b1;
        sample();
        chk("ackerr_err", 64'(m0_err_o), 64'(1'b1));
        chk("ackerr_ack", 64'(m0_ack_o), 64'(1'b0));
        tick();
        idle_inputs();
        step();

        // M1 aborts mid-wait; a late ACK is ignored and the watchdog restarts from zero
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        step();
        step();
        step();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        s_ack_i = 1'b1;
        sample();
        chk("late_ack_m1", 64'(m1_ack_o), 64'(1'b0));
        chk("late_ack_m0", 64'(m0_ack_o), 64'(1'b0));
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            sample();
            chk("abort_wd_cleared", 64'(m1_err_o), 64'(k == 5));
            tick();
        end
        idle_inputs();
        step();

        // Random traffic: sticky CYC, slow and fast slave phases
        c0 = 1'b0; c1 = 1'b0;
        for (int j = 0; j < 600; j++) begin
            if ($urandom_range(0, 7) == 0) c0 = !c0;
            if ($urandom_range(0, 7) == 0) c1 = !c1;
            m0_cyc_i = c0; m0_stb_i = ($urandom_range(0, 3) != 0); m0_we_i = 1'($urandom);
            m0_sel_i = 4'($urandom); m0_addr_i = $urandom; m0_dat_i = $urandom;
            m1_cyc_i = c1; m1_stb_i = ($urandom_range(0, 3) != 0); m1_we_i = 1'($urandom);
            m1_sel_i = 4'($urandom); m1_addr_i = $urandom; m1_dat_i = $urandom;
            s_dat_i  = $urandom;
            s_ack_i  = ((j / 100) % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
            s_err_i  = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
